lfsr_checker: RTL and testbench

Receive-side checker for the 32-bit pseudo-random data stream produced by the `lfsr` generator. The checker self-synchronises by seeding a local LFSR from the incoming words. It declares lock after a run of correct predictions, then counts and flags mismatches. It sits downstream of the generator, or of any path carrying its data, to prove bit-exact transport in simulation and on hardware.

---
 rtl/lfsr_pkg.sv | 30 +++
 rtl/lfsr_checker.sv | 167 ++++++++++++++++
 tb/tb_lfsr_checker.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR widths, recurrences and checker state encoding
//
// Shared by the lfsr generator and lfsr_checker so that both sides use one
// definition of each recurrence.
//   DATA_W       : width of the data LFSR word
//   ADDR_W       : width of the address LFSR word
//   lfsr32_next  : data recurrence, taps 32, 22, 2, 1 (maximal length, nonzero)
//   lfsr10_next  : address recurrence, taps 10, 7 (maximal length, nonzero)
//   chk_state_t  : checker synchronisation states

package lfsr_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    function automatic logic [DATA_W-1:0] lfsr32_next(input logic [DATA_W-1:0] cur);
        return {cur[30:0], cur[31] ^ cur[21] ^ cur[1] ^ cur[0]};
    endfunction

    function automatic logic [ADDR_W-1:0] lfsr10_next(input logic [ADDR_W-1:0] cur);
        return {cur[8:0], cur[9] ^ cur[6]};
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising checker for the 32-bit lfsr data stream
//
// Seeds a local predictor from the received words, declares lock after
// LOCK_CNT consecutive correct predictions, then flags and counts mismatches
// until LOSS_CNT consecutive misses drop lock.
//   clk        : single clock
//   rst        : synchronous, active-high reset
//   en_data    : lfsr_data is valid; one word consumed per cycle while high
//   lfsr_data  : received word
//   clr_cnt    : synchronous clear of err_count
//   locked     : predictor is synchronised (registered)
//   err_pulse  : one-cycle flag for a mismatch seen while locked (registered)
//   err_count  : saturating count of mismatches seen while locked (registered)
//   expected   : prediction for the next word (registered)

module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_data,
    input  logic [DATA_W-1:0] lfsr_data,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              err_pulse,
    output logic [15:0]       err_count,
    output logic [DATA_W-1:0] expected
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

    chk_state_t        state;
    chk_state_t        state_nx;
    logic [DATA_W-1:0] exp_q;
    logic [DATA_W-1:0] exp_nx;
    logic [3:0]        match_q;
    logic [3:0]        match_nx;
    logic [3:0]        miss_q;
    logic [3:0]        miss_nx;
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_nx;
    logic              pulse_q;
    logic              locked_q;
    logic              count_err;

    logic              hit;
    logic              word_nz;
    logic [3:0]        match_inc;
    logic [3:0]        miss_inc;

    assign hit       = (lfsr_data == exp_q);
    assign word_nz   = (lfsr_data != '0);
    assign match_inc = match_q + 4'd1;
    assign miss_inc  = miss_q + 4'd1;

    // State and output registers; locked tracks the state being entered so it
    // is a flop rather than a decode of the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            exp_q    <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state    <= state_nx;
            exp_q    <= exp_nx;
            match_q  <= match_nx;
            miss_q   <= miss_nx;
            cnt_q    <= cnt_nx;
            pulse_q  <= count_err;
            locked_q <= (state_nx == LOCKED);
        end
    end

    // Next-state logic. Only consumed words advance the machine.
    always_comb begin
        state_nx = state;
        if (en_data) begin
            case (state)
                HUNT: begin
                    if (word_nz) state_nx = VERIFY;
                end
                VERIFY: begin
                    if (hit) begin
                        if (match_inc == LOCK_N) state_nx = LOCKED;
                    end else if (!word_nz) begin
                        state_nx = HUNT;
                    end
                end
                LOCKED: begin
                    if (!hit && (miss_inc == LOSS_N)) state_nx = HUNT;
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    // Predictor, run counters and error accounting.
    always_comb begin
        exp_nx    = exp_q;
        match_nx  = match_q;
        miss_nx   = miss_q;
        count_err = 1'b0;
        if (en_data) begin
            case (state)
                HUNT: begin
                    // All-zero is not on the sequence and cannot seed it.
                    if (word_nz) begin
                        exp_nx   = lfsr32_next(lfsr_data);
                        match_nx = '0;
                    end
                end
                VERIFY: begin
                    if (hit) begin
                        exp_nx   = lfsr32_next(exp_q);
                        match_nx = match_inc;
                    end else begin
                        match_nx = '0;
                        if (word_nz) exp_nx = lfsr32_next(lfsr_data);
                    end
                end
                LOCKED: begin
                    // Free-running: a corrupted word must not poison the predictor.
                    exp_nx = lfsr32_next(exp_q);
                    if (hit) begin
                        miss_nx = '0;
                    end else begin
                        count_err = 1'b1;
                        if (miss_inc == LOSS_N) begin
                            miss_nx  = '0;
                            match_nx = '0;
                        end else begin
                            miss_nx = miss_inc;
                        end
                    end
                end
                default: begin
                    match_nx = '0;
                    miss_nx  = '0;
                end
            endcase
        end
    end

    // A clear coinciding with a counted mismatch keeps that mismatch.
    always_comb begin
        cnt_nx = cnt_q;
        if (clr_cnt) begin
            cnt_nx = count_err ? 16'd1 : 16'd0;
        end else if (count_err && (cnt_q != 16'hFFFF)) begin
            cnt_nx = cnt_q + 16'd1;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = pulse_q;
    assign err_count = cnt_q;
    assign expected  = exp_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - self-checking bench for lfsr_checker

module tb_lfsr_checker;

    localparam int M_LOCK = 4;
    localparam int M_LOSS = 3;

    typedef struct packed {
        logic        locked;
        logic        pulse;
        logic [15:0] cnt;
        logic [31:0] exp;
    } obs_t;

    typedef struct {
        logic        rst;
        logic        en;
        logic [31:0] data;
        logic        clr;
        obs_t        want;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_a, en_a, clr_a;
    logic [31:0] data_a;
    logic        locked_a, pulse_a;
    logic [15:0] cnt_a;
    logic [31:0] exp_a;
    logic        rst_b, en_b, clr_b;
    logic [31:0] data_b;
    logic        locked_b, pulse_b;
    logic [15:0] cnt_b;
    logic [31:0] exp_b;

    int n_vec = 0;
    int n_err = 0;

    obs_t sb[$];
    vec_t tab[12];

    int          m_st;
    logic [31:0] m_exp;
    int          m_match;
    int          m_miss;
    int          m_cnt;
    logic        m_pulse;

    always #5 clk = ~clk;

    lfsr_checker u_a (
        .clk(clk), .rst(rst_a), .en_data(en_a), .lfsr_data(data_a), .clr_cnt(clr_a),
        .locked(locked_a), .err_pulse(pulse_a), .err_count(cnt_a), .expected(exp_a)
    );

    lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(15)) u_b (
        .clk(clk), .rst(rst_b), .en_data(en_b), .lfsr_data(data_b), .clr_cnt(clr_b),
        .locked(locked_b), .err_pulse(pulse_b), .err_count(cnt_b), .expected(exp_b)
    );

    function automatic logic [31:0] tb_next(input logic [31:0] v);
        logic fb;
        fb = v[31] ^ v[21] ^ v[1] ^ v[0];
        return (v << 1) | {31'b0, fb};
    endfunction

    function automatic vec_t mk(input logic r, input logic e, input logic [31:0] d, input logic c,
                                input logic lk, input logic pl, input logic [15:0] cn,
                                input logic [31:0] ex);
        vec_t v;
        v.rst = r; v.en = e; v.data = d; v.clr = c;
        v.want.locked = lk; v.want.pulse = pl; v.want.cnt = cn; v.want.exp = ex;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic [31:0] d,
                              input logic c, output obs_t o);
        bit counted;
        counted = 0;
        if (r) begin
            m_st = 0; m_exp = '0; m_match = 0; m_miss = 0; m_cnt = 0; m_pulse = 0;
        end else begin
            m_pulse = 0;
            if (e) begin
                if (m_st == 0) begin
                    if (d != 0) begin m_exp = tb_next(d); m_match = 0; m_st = 1; end
                end else if (m_st == 1) begin
                    if (d == m_exp) begin
                        m_exp = tb_next(m_exp);
                        m_match++;
                        if (m_match == M_LOCK) m_st = 2;
                    end else begin
                        m_match = 0;
                        if (d == 0) m_st = 0;
                        else m_exp = tb_next(d);
                    end
                end else begin
                    counted = (d != m_exp);
                    m_exp = tb_next(m_exp);
                    if (!counted) m_miss = 0;
                    else begin
                        m_pulse = 1;
                        m_miss++;
                        if (m_miss == M_LOSS) begin m_st = 0; m_match = 0; m_miss = 0; end
                    end
                end
            end
            if (c) m_cnt = counted ? 1 : 0;
            else if (counted && m_cnt < 65535) m_cnt++;
        end
        o.locked = (m_st == 2);
        o.pulse  = m_pulse;
        o.cnt    = 16'(m_cnt);
        o.exp    = m_exp;
    endtask

    task automatic check_a();
        obs_t w;
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard_empty: got no expectation, want one");
        end else begin
            w = sb.pop_front();
            cmp("locked", {31'b0, locked_a}, {31'b0, w.locked});
            cmp("err_pulse", {31'b0, pulse_a}, {31'b0, w.pulse});
            cmp("err_count", {16'b0, cnt_a}, {16'b0, w.cnt});
            cmp("expected", exp_a, w.exp);
        end
    endtask

    task automatic drive_a(input logic r, input logic e, input logic [31:0] d, input logic c,
                           input bit ovr, input obs_t want);
        obs_t m;
        rst_a = r; en_a = e; data_a = d; clr_a = c;
        model_step(r, e, d, c, m);
        sb.push_back(ovr ? want : m);
        @(posedge clk); #1;
        check_a();
    endtask

    task automatic step_a(input logic r, input logic e, input logic [31:0] d, input logic c);
        drive_a(r, e, d, c, 1'b0, '0);
    endtask

    task automatic drive_b(input logic r, input logic e, input logic [31:0] d, input logic c);
        rst_b = r; en_b = e; data_b = d; clr_b = c;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] be;
        int misses;
        int bcnt;

        rst_a = 1'b1; en_a = 1'b0; data_a = '0; clr_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0; data_b = '0; clr_b = 1'b0;
        m_st = 0; m_exp = '0; m_match = 0; m_miss = 0; m_cnt = 0; m_pulse = 0;
        repeat (2) @(posedge clk);
        #1;

        // reset, zeros in HUNT, clean lock, single error
        tab[0]  = mk(1, 0, 32'h0,        0, 0, 0, 16'd0, 32'h0);
        tab[1]  = mk(0, 1, 32'h0,        0, 0, 0, 16'd0, 32'h0);
        tab[2]  = mk(0, 1, 32'h0,        0, 0, 0, 16'd0, 32'h0);
        tab[3]  = mk(0, 1, 32'h1,        0, 0, 0, 16'd0, 32'h3);
        tab[4]  = mk(0, 1, 32'h3,        0, 0, 0, 16'd0, 32'h6);
        tab[5]  = mk(0, 1, 32'h6,        0, 0, 0, 16'd0, 32'hD);
        tab[6]  = mk(0, 1, 32'hD,        0, 0, 0, 16'd0, 32'h1B);
        tab[7]  = mk(0, 1, 32'h1B,       0, 1, 0, 16'd0, 32'h36);
        tab[8]  = mk(0, 1, 32'h36,       0, 1, 0, 16'd0, 32'h6D);
        tab[9]  = mk(0, 1, 32'h8000006D, 0, 1, 1, 16'd1, 32'hDB);
        tab[10] = mk(0, 1, 32'hDB,       0, 1, 0, 16'd1, 32'h1B6);
        tab[11] = mk(0, 1, 32'h1B6,      0, 1, 0, 16'd1, 32'h36D);
        for (int i = 0; i < 12; i++)
            drive_a(tab[i].rst, tab[i].en, tab[i].data, tab[i].clr, 1'b1, tab[i].want);

        // loss of lock from a cleared count, then relock on a new seed
        step_a(0, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) step_a(0, 1, m_exp ^ 32'h1, 0);
        cmp("loss_locked", {31'b0, locked_a}, 32'd0);
        cmp("loss_count", {16'b0, cnt_a}, 32'd3);
        d = 32'h12345678;
        for (int i = 0; i < 5; i++) begin step_a(0, 1, d, 0); d = tb_next(d); end
        cmp("relock_locked", {31'b0, locked_a}, 32'd1);
        cmp("relock_count", {16'b0, cnt_a}, 32'd3);

        // drop lock again, then a wrong word in VERIFY reseeds without counting
        for (int i = 0; i < 3; i++) step_a(0, 1, m_exp ^ 32'h4, 0);
        step_a(0, 1, 32'h1, 0);
        step_a(0, 1, 32'h3, 0);
        step_a(0, 1, 32'h55, 0);
        cmp("verify_reseed_exp", exp_a, tb_next(32'h55));
        cmp("verify_count", {16'b0, cnt_a}, 32'd6);
        step_a(0, 1, 32'h0, 0);
        step_a(0, 1, 32'h0, 0);

        // relock, set err_count to 2, then reset while locked
        d = 32'h1;
        for (int i = 0; i < 5; i++) begin step_a(0, 1, d, 0); d = tb_next(d); end
        step_a(0, 0, 32'h0, 1);
        step_a(0, 1, m_exp ^ 32'h100, 0);
        step_a(0, 1, m_exp ^ 32'h100, 0);
        step_a(0, 1, m_exp, 0);
        cmp("pre_reset_count", {16'b0, cnt_a}, 32'd2);
        step_a(1, 1, m_exp ^ 32'h1, 1);
        cmp("reset_locked", {31'b0, locked_a}, 32'd0);
        cmp("reset_expected", exp_a, 32'd0);
        d = 32'h1;
        for (int i = 0; i < 5; i++) begin step_a(0, 1, d, 0); d = tb_next(d); end
        cmp("reset_relock_exp", exp_a, 32'h36);

        // gaps in en_data during the lock sequence
        step_a(1, 0, 32'h0, 0);
        d = 32'h1;
        for (int i = 0; i < 5; i++) begin
            step_a(0, 1, d, 0);
            d = tb_next(d);
            step_a(0, 0, $urandom, 0);
        end
        cmp("gap_locked", {31'b0, locked_a}, 32'd1);

        // clear coinciding with a counted mismatch
        step_a(0, 1, m_exp ^ 32'h2, 0);
        step_a(0, 1, m_exp ^ 32'h2, 1);
        cmp("clr_with_miss", {16'b0, cnt_a}, 32'd1);
        step_a(0, 1, m_exp, 0);
        step_a(0, 0, 32'h0, 0);

        // saturation on the LOSS_CNT=15 instance
        drive_b(1, 0, 32'h0, 0);
        d = 32'h1;
        for (int i = 0; i < 5; i++) begin drive_b(0, 1, d, 0); d = tb_next(d); end
        cmp("b_locked", {31'b0, locked_b}, 32'd1);
        cmp("b_expected", exp_b, 32'h36);
        be = 32'h36;
        misses = 0;
        bcnt = 0;
        while (misses < 70000) begin
            for (int k = 0; k < 14 && misses < 70000; k++) begin
                drive_b(0, 1, be ^ 32'h1, 0);
                be = tb_next(be);
                misses++;
                if (bcnt < 65535) bcnt++;
                cmp("b_pulse", {31'b0, pulse_b}, 32'd1);
                cmp("b_count", {16'b0, cnt_b}, bcnt);
            end
            drive_b(0, 1, be, 0);
            be = tb_next(be);
            cmp("b_pulse_match", {31'b0, pulse_b}, 32'd0);
        end
        cmp("b_saturated", {16'b0, cnt_b}, 32'hFFFF);
        cmp("b_still_locked", {31'b0, locked_b}, 32'd1);

        if (sb.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard_left: got %0d entries, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
